// File: rtl/bitrev_spi_slave.sv
// bitrev_spi_slave
//   SPI-mode-0/2 slave (CPHA = 0, CPOL selectable) running on the system clock.
//   It receives a DATA_W-bit word MSB-first, then returns the bit-reversed word
//   over the next DATA_W bit times. Back-to-back frames are allowed under one
//   slave select.
//
// Ports
//   clock        system clock; all state changes on its rising edge
//   reset        synchronous, active-high
//   spi_sck      SPI clock (asynchronous, oversampled)
//   spi_ss       slave select, active low (asynchronous)
//   spi_mosi     master-out data (asynchronous)
//   spi_miso     slave-out data; idles high outside SEND
//   busy         high while a frame is in RECV or SEND
//   done         one-cycle pulse when a frame has been fully transmitted
//   abort        one-cycle pulse when ss is released part-way through a frame
//   rx_data      last fully received word
//   frame_count  completed frames, wraps modulo 2^CNT_W

// One synchroniser lane: a plain STAGES-deep flop chain. RST_VAL lets each
// pin reset to its idle level so no phantom edge or select appears after reset.
module bitrev_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] pipe;

    always_ff @(posedge clock) begin
        if (reset) pipe <= {STAGES{RST_VAL}};
        else       pipe <= {pipe[STAGES-2:0], d};
    end

    assign q = pipe[STAGES-1];
endmodule

module bitrev_spi_slave #(
    parameter int DATA_W      = 8,
    parameter int CPOL        = 0,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              spi_sck,
    input  logic              spi_ss,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              busy,
    output logic              done,
    output logic              abort,
    output logic [DATA_W-1:0] rx_data,
    output logic [CNT_W-1:0]  frame_count
);
    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RECV = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;

    // Lane order {mosi, ss, sck}; sck resets to its idle level, ss to inactive.
    localparam logic       SCK_IDLE = (CPOL != 0) ? 1'b1 : 1'b0;
    localparam logic [2:0] SYNC_RST = {1'b0, 1'b1, SCK_IDLE};

    logic [2:0] pin_raw, pin_s;
    logic       sck_s, ss_s, mosi_s, sck_d;
    logic       rise, fall, sample_edge, shift_edge;

    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic [DATA_W-2:0] shreg;   // first DATA_W-1 bits; the last bit goes straight to word_in
    logic [DATA_W-1:0] txreg;
    logic [DATA_W-1:0] word_in;

    assign pin_raw = {spi_mosi, spi_ss, spi_sck};

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_sync
            bitrev_sync #(
                .STAGES  (SYNC_STAGES),
                .RST_VAL (SYNC_RST[g])
            ) u_sync (
                .clock (clock),
                .reset (reset),
                .d     (pin_raw[g]),
                .q     (pin_s[g])
            );
        end
    endgenerate

    assign sck_s  = pin_s[0];
    assign ss_s   = pin_s[1];
    assign mosi_s = pin_s[2];

    // Extra sck register for edge detection.
    always_ff @(posedge clock) begin
        if (reset) sck_d <= SCK_IDLE;
        else       sck_d <= sck_s;
    end

    assign rise = sck_s & ~sck_d;
    assign fall = ~sck_s & sck_d;

    // CPHA = 0: sample on the leading edge away from idle, shift on the trailing one.
    assign sample_edge = (CPOL != 0) ? fall : rise;
    assign shift_edge  = (CPOL != 0) ? rise : fall;

    assign word_in = {shreg, mosi_s};

    function automatic logic [DATA_W-1:0] bitrev(input logic [DATA_W-1:0] w);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < DATA_W; i++) r[i] = w[DATA_W-1-i];
        return r;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            shreg       <= '0;
            txreg       <= '0;
            rx_data     <= '0;
            frame_count <= '0;
            done        <= 1'b0;
            abort       <= 1'b0;
        end else begin
            done  <= 1'b0;
            abort <= 1'b0;
            case (state)
                S_IDLE: begin
                    // sck edges here are ignored; only select matters.
                    if (!ss_s) begin
                        state <= S_RECV;
                        cnt   <= '0;
                        shreg <= '0;
                    end
                end

                S_RECV: begin
                    if (ss_s) begin
                        // Release right after done (nothing received yet) is a clean end.
                        state <= S_IDLE;
                        abort <= (cnt != '0);
                        cnt   <= '0;
                    end else if (sample_edge) begin
                        shreg <= word_in[DATA_W-2:0];
                        if (cnt == LAST) begin
                            rx_data <= word_in;
                            txreg   <= bitrev(word_in);
                            cnt     <= '0;
                            state   <= S_SEND;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end

                S_SEND: begin
                    if (ss_s) begin
                        // Select wins over a coincident sample edge, even the final one.
                        state <= S_IDLE;
                        abort <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        if (sample_edge) begin
                            if (cnt == LAST) begin
                                done        <= 1'b1;
                                frame_count <= frame_count + CNT_W'(1);
                                cnt         <= '0;
                                shreg       <= '0;
                                state       <= S_RECV;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end
                        // The shift edge before the first SEND sample must not
                        // disturb the first bit, so hold until cnt has moved.
                        if (shift_edge && cnt != '0)
                            txreg <= {txreg[DATA_W-2:0], 1'b0};
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy     = (state != S_IDLE);
    assign spi_miso = (state == S_SEND) ? txreg[DATA_W-1] : 1'b1;
endmodule

// File: tb/tb_bitrev_spi_slave.sv
module tb_bitrev_spi_slave;
    localparam int SS = 2;
    localparam int H  = SS + 4;   // clocks per sck phase, above the minimum hold

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    // Shared master pins, routed to instance A/C (sel=0) or B (sel=1).
    logic m_sck, m_ss, m_mosi;
    logic sel;
    int   cpol_cur, w_cur;

    logic sck_a, ss_a, mosi_a, sck_b, ss_b, mosi_b;
    assign sck_a  = sel ? 1'b0 : m_sck;
    assign ss_a   = sel ? 1'b1 : m_ss;
    assign mosi_a = sel ? 1'b0 : m_mosi;
    assign sck_b  = sel ? m_sck : 1'b1;
    assign ss_b   = sel ? m_ss : 1'b1;
    assign mosi_b = sel ? m_mosi : 1'b0;

    logic        miso_a, busy_a, done_a, abort_a;
    logic [7:0]  rx_a;
    logic [15:0] fc_a;
    logic        miso_b, busy_b, done_b, abort_b;
    logic [15:0] rx_b, fc_b;
    logic        miso_c, busy_c, done_c, abort_c;
    logic [7:0]  rx_c;
    logic [1:0]  fc_c;

    bitrev_spi_slave #(.DATA_W(8), .CPOL(0), .SYNC_STAGES(SS), .CNT_W(16)) u_a (
        .clock(clock), .reset(reset), .spi_sck(sck_a), .spi_ss(ss_a), .spi_mosi(mosi_a),
        .spi_miso(miso_a), .busy(busy_a), .done(done_a), .abort(abort_a),
        .rx_data(rx_a), .frame_count(fc_a));

    bitrev_spi_slave #(.DATA_W(16), .CPOL(1), .SYNC_STAGES(SS), .CNT_W(16)) u_b (
        .clock(clock), .reset(reset), .spi_sck(sck_b), .spi_ss(ss_b), .spi_mosi(mosi_b),
        .spi_miso(miso_b), .busy(busy_b), .done(done_b), .abort(abort_b),
        .rx_data(rx_b), .frame_count(fc_b));

    // Narrow frame counter instance listening to the same pins as A.
    bitrev_spi_slave #(.DATA_W(8), .CPOL(0), .SYNC_STAGES(SS), .CNT_W(2)) u_c (
        .clock(clock), .reset(reset), .spi_sck(sck_a), .spi_ss(ss_a), .spi_mosi(mosi_a),
        .spi_miso(miso_c), .busy(busy_c), .done(done_c), .abort(abort_c),
        .rx_data(rx_c), .frame_count(fc_c));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Pulse counters and cross-checks, sampled on the inactive edge.
    int done_cnt_a = 0, abort_cnt_a = 0, done_cnt_b = 0, abort_cnt_b = 0, busy_falls_a = 0;
    logic        busy_prev_a = 1'b0;
    logic [15:0] fc_prev_a = '0;
    always @(negedge clock) begin
        if (done_a) begin
            done_cnt_a++;
            chk("done_with_fc_a", {16'h0, fc_a}, {16'h0, fc_prev_a + 16'd1});
        end
        if (abort_a) abort_cnt_a++;
        if (done_b)  done_cnt_b++;
        if (abort_b) abort_cnt_b++;
        if (busy_prev_a && !busy_a) busy_falls_a++;
        busy_prev_a = busy_a;
        fc_prev_a   = fc_a;
    end

    // Reference model: reply is the received word with bit i moved to position w-1-i.
    function automatic logic [15:0] rev(input logic [15:0] d, input int w);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < w; i++)
            if (d[i]) r = r | (16'd1 << (w - 1 - i));
        return r;
    endfunction

    logic [7:0]  exp_rx_a;
    int          exp_fc_a, exp_done_a, exp_abort_a;
    logic [15:0] exp_rx_b;
    int          exp_fc_b, exp_done_b;

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    // One sck period: present mosi, sample edge (master reads miso), trailing edge.
    task automatic bit_cycle(input logic mi, output logic mo);
        m_mosi = mi;
        wait_clk(H);
        mo = sel ? miso_b : miso_a;
        m_sck = (cpol_cur != 0) ? 1'b0 : 1'b1;
        wait_clk(H);
        m_sck = (cpol_cur != 0) ? 1'b1 : 1'b0;
    endtask

    task automatic ss_begin();
        m_ss = 1'b0;
        wait_clk(H);
    endtask

    task automatic ss_end();
        wait_clk(H);
        m_ss = 1'b1;
        wait_clk(H);
    endtask

    // Full frame under an already-asserted select: w_cur bits out, w_cur bits back.
    task automatic frame(input logic [15:0] din, output logic [15:0] reply);
        logic b;
        for (int i = w_cur - 1; i >= 0; i--) bit_cycle(din[i], b);
        reply = '0;
        for (int i = 0; i < w_cur; i++) begin
            bit_cycle(1'b0, b);
            reply = {reply[14:0], b};
        end
    endtask

    task automatic check_a(input string tag);
        chk({tag, "_rx_a"},    {24'h0, rx_a},   {24'h0, exp_rx_a});
        chk({tag, "_fc_a"},    {16'h0, fc_a},   32'(exp_fc_a % 65536));
        chk({tag, "_fc_c"},    {30'h0, fc_c},   32'(exp_fc_a % 4));
        chk({tag, "_rx_c"},    {24'h0, rx_c},   {24'h0, exp_rx_a});
        chk({tag, "_done"},    32'(done_cnt_a), 32'(exp_done_a));
        chk({tag, "_abort"},   32'(abort_cnt_a), 32'(exp_abort_a));
        chk({tag, "_busy"},    {31'h0, busy_a}, 32'h0);
        chk({tag, "_miso_idle"}, {31'h0, miso_a}, 32'h1);
    endtask

    // mode 0: full frame; 1: release after k received bits; 2: release after k sent bits.
    task automatic do_op(input logic [7:0] din, input int mode, input int k, input string tag);
        logic [15:0] reply;
        logic b;
        ss_begin();
        if (mode == 0) begin
            frame({8'h0, din}, reply);
            chk({tag, "_reply"}, {16'h0, reply}, {16'h0, rev({8'h0, din}, 8)});
            exp_rx_a = din;
            exp_fc_a++;
            exp_done_a++;
        end else if (mode == 1) begin
            for (int j = 0; j < k; j++) bit_cycle(din[7-j], b);
            exp_abort_a++;
        end else begin
            for (int j = 0; j < 8; j++) bit_cycle(din[7-j], b);
            for (int j = 0; j < k; j++) bit_cycle(1'b0, b);
            exp_rx_a = din;
            exp_abort_a++;
        end
        ss_end();
        check_a(tag);
    endtask

    typedef struct {
        logic [7:0] din;
        int         abort_at;    // 0 = complete frame
        logic [7:0] exp_reply;
        logic [7:0] exp_rx;
        int         exp_fc;
    } vec_t;

    vec_t tbl[3];

    initial begin
        logic [15:0] reply;
        logic [15:0] w16;
        logic b;
        int busy_snap;

        tbl[0] = '{din: 8'h01, abort_at: 0, exp_reply: 8'h80, exp_rx: 8'h01, exp_fc: 1};
        tbl[1] = '{din: 8'hFF, abort_at: 5, exp_reply: 8'h00, exp_rx: 8'h01, exp_fc: 1};
        tbl[2] = '{din: 8'h0F, abort_at: 0, exp_reply: 8'hF0, exp_rx: 8'h0F, exp_fc: 2};

        sel = 1'b0; cpol_cur = 0; w_cur = 8;
        m_sck = 1'b0; m_ss = 1'b1; m_mosi = 1'b0;
        reset = 1'b1;
        exp_rx_a = '0; exp_fc_a = 0; exp_done_a = 0; exp_abort_a = 0;
        exp_rx_b = '0; exp_fc_b = 0; exp_done_b = 0;
        wait_clk(4);
        reset = 1'b0;
        wait_clk(2);
        check_a("reset");
        chk("reset_done_a",  {31'h0, done_a},  32'h0);
        chk("reset_abort_a", {31'h0, abort_a}, 32'h0);
        chk("reset_rx_b",    {16'h0, rx_b},    32'h0);
        chk("reset_miso_b",  {31'h0, miso_b},  32'h1);

        // Table: single frames and an abort mid-receive.
        for (int i = 0; i < 3; i++) begin
            ss_begin();
            if (tbl[i].abort_at == 0) begin
                frame({8'h0, tbl[i].din}, reply);
                chk("tbl_reply", {16'h0, reply}, {24'h0, tbl[i].exp_reply});
                exp_done_a++;
                exp_fc_a++;
                exp_rx_a = tbl[i].din;
            end else begin
                for (int j = 0; j < tbl[i].abort_at; j++) bit_cycle(tbl[i].din[7-j], b);
                exp_abort_a++;
            end
            ss_end();
            chk("tbl_rx", {24'h0, rx_a}, {24'h0, tbl[i].exp_rx});
            chk("tbl_fc", {16'h0, fc_a}, 32'(tbl[i].exp_fc));
            check_a("tbl");
        end

        // Back-to-back frames under one select; busy must not drop in between.
        ss_begin();
        busy_snap = busy_falls_a;
        frame(16'h00A5, reply);
        chk("b2b_reply0", {16'h0, reply}, 32'hA5);
        frame(16'h003C, reply);
        chk("b2b_reply1", {16'h0, reply}, 32'h3C);
        chk("b2b_busy_held", 32'(busy_falls_a), 32'(busy_snap));
        chk("b2b_busy_hi", {31'h0, busy_a}, 32'h1);
        ss_end();
        exp_done_a += 2; exp_fc_a += 2; exp_rx_a = 8'h3C;
        check_a("b2b");

        // Wide word, inverted clock polarity.
        m_sck = 1'b1; cpol_cur = 1; w_cur = 16; sel = 1'b1;
        wait_clk(H);
        for (int i = 0; i < 4; i++) begin
            w16 = (i == 0) ? 16'h1234 : 16'($urandom);
            ss_begin();
            frame(w16, reply);
            ss_end();
            exp_rx_b = w16; exp_fc_b++; exp_done_b++;
            chk("w16_reply", {16'h0, reply}, {16'h0, rev(w16, 16)});
            chk("w16_rx",    {16'h0, rx_b},  {16'h0, exp_rx_b});
            chk("w16_fc",    {16'h0, fc_b},  32'(exp_fc_b));
            chk("w16_done",  32'(done_cnt_b), 32'(exp_done_b));
            chk("w16_abort", 32'(abort_cnt_b), 32'h0);
        end
        chk("w16_first_fixed", 32'(rev(16'h1234, 16)), 32'h2C48);
        m_sck = 1'b0; cpol_cur = 0; w_cur = 8; sel = 1'b0;
        wait_clk(H);

        // Fresh start: five frames wrap the narrow counter, then random traffic.
        reset = 1'b1;
        wait_clk(3);
        reset = 1'b0;
        wait_clk(2);
        exp_rx_a = '0; exp_fc_a = 0;
        for (int i = 0; i < 5; i++) do_op(8'($urandom), 0, 0, "wrap");
        for (int i = 0; i < 8; i++) begin
            int mode;
            mode = $urandom_range(0, 3);
            if (mode == 3) mode = $urandom_range(1, 2);
            if (mode == 1) do_op(8'($urandom), 1, $urandom_range(1, 7), "rnd_rabort");
            else if (mode == 2) do_op(8'($urandom), 2, $urandom_range(0, 7), "rnd_sabort");
            else do_op(8'($urandom), 0, 0, "rnd_full");
        end

        // Reset while the second reply bit is on the wire.
        ss_begin();
        for (int j = 0; j < 8; j++) bit_cycle(j[0], b);
        bit_cycle(1'b0, b);
        wait_clk(2);
        chk("pre_rst_busy", {31'h0, busy_a}, 32'h1);
        reset = 1'b1;
        wait_clk(1);
        chk("rst_busy",  {31'h0, busy_a},  32'h0);
        chk("rst_done",  {31'h0, done_a},  32'h0);
        chk("rst_abort", {31'h0, abort_a}, 32'h0);
        chk("rst_rx",    {24'h0, rx_a},    32'h0);
        chk("rst_fc",    {16'h0, fc_a},    32'h0);
        chk("rst_miso",  {31'h0, miso_a},  32'h1);
        m_ss = 1'b1;
        wait_clk(4);
        reset = 1'b0;
        wait_clk(H);
        exp_rx_a = '0; exp_fc_a = 0;
        check_a("after_rst");
        do_op(8'h80, 0, 0, "post_rst");
        chk("post_rst_rx", {24'h0, rx_a}, 32'h80);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bitrev_spi_slave.md
# bitrev_spi_slave

Parametrised SPI-slave bit-reversal test peripheral, successor to the fixed 8-bit sck-clocked bit-reversal slave. It runs on the SoC system clock, oversamples the SPI pins through synchronisers, receives a DATA_W-bit word MSB-first, then returns the bit-reversed word on the next DATA_W bit times. It supports back-to-back frames under one chip-select, selectable clock polarity, abort detection and a frame counter for the bench/status logic. It sits on the SPI master's slave-select line alongside the flash/PSRAM models.

## Interface
- DATA_W, 8: word width in bits (≥2).
- CPOL, 0: sck idle level; 0 → sample on rising sck, shift on falling; 1 → sample on falling, shift on rising. CPHA is fixed at 0.
- SYNC_STAGES, 2: flip-flops in each pin synchroniser (≥2).
- CNT_W, 16: frame_count width.

- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- spi_sck  in  1  SPI clock (asynchronous to clock).
- spi_ss  in  1  slave select, active low (asynchronous).
- spi_mosi  in  1  master-out data (asynchronous).
- spi_miso  out  1  slave-out data.
- busy  out  1  high while in RECV or SEND.
- done  out  1  one-cycle pulse: frame fully transmitted.
- abort  out  1  one-cycle pulse: ss released mid-frame.
- rx_data  out  DATA_W  last fully received word.
- frame_count  out  CNT_W  completed frames, wraps modulo 2^CNT_W.

## Operation
- sck, ss and mosi each pass through SYNC_STAGES flops; one extra register on sck gives edge detection. sample_edge/shift_edge are one-cycle strobes per CPOL.
- States: IDLE, RECV, SEND.
- IDLE: spi_miso = 1. Synchronised ss low → RECV, bit counter = 0, shift register cleared.
- RECV: on each sample_edge, shreg ← {shreg[DATA_W-2:0], mosi}, counter +1. spi_miso = 1. On the DATA_W-th sample_edge: rx_data ← the completed word, txreg ← bit-reverse(completed word), counter = 0 → SEND.
- SEND: spi_miso = txreg[DATA_W-1] (first bit out = last bit received). On each sample_edge, counter +1. On each shift_edge that follows at least one SEND sample_edge, txreg shifts left by one. On the DATA_W-th sample_edge: done pulse, frame_count +1, → RECV with counter 0 (back-to-back frame while ss stays low).
- ss released (synchronised high) in RECV or SEND: → IDLE, abort pulse, rx_data and frame_count unchanged, spi_miso = 1 next cycle. ss release in RECV with counter 0 and no bits received (i.e. just after done) → IDLE without abort.
- Simultaneous ss release and sample_edge in the same clock: ss wins. The edge is ignored. If it would have completed a frame, the frame is aborted (abort, no done).
- Edges seen while in IDLE are ignored.
- Bit-reverse: txreg[i] = word[DATA_W-1-i].

## Timing
- Reset (synchronous): state IDLE, spi_miso 1, busy 0, done 0, abort 0, rx_data 0, frame_count 0, counters and shift registers 0. Reset mid-frame discards the frame with no done and no abort.
- Pin-to-strobe latency: SYNC_STAGES+1 clocks. spi_miso settles within SYNC_STAGES+2 clocks of the sck shift edge.
- The master must hold each sck phase ≥ SYNC_STAGES+3 clocks, and must assert ss ≥ SYNC_STAGES+2 clocks before the first sample edge.
- rx_data updates in the cycle after the last RECV sample_edge is detected. It holds until the next completed receive.
- done and frame_count update together, in the cycle after the last SEND sample_edge is detected.
- busy rises the cycle after synchronised ss low and falls the cycle after IDLE is re-entered.

## Test plan
- Reset, then one frame with defaults, mosi = 0x01 → miso returns 0x80 MSB-first; rx_data = 0x01; one done pulse; frame_count = 1; abort never high.
- Two back-to-back frames under one ss, 0xA5 then 0x3C → miso returns 0xA5 then 0x3C; two done pulses; frame_count = 2; busy stays high until ss released.
- ss released after 5 bits of 0xFF → abort pulse once; rx_data unchanged; frame_count unchanged; miso = 1; the next full frame 0x0F returns 0xF0.
- DATA_W = 16, CPOL = 1 instance, mosi = 0x1234 → miso returns 0x2C48; rx_data = 0x1234.
- CNT_W = 2, five complete frames → frame_count sequence 1, 2, 3, 0, 1.
- Reset asserted during SEND of the second bit → all outputs at reset values next cycle; no done or abort; the following frame 0x80 returns 0x01.
